id_stage: RTL and testbench

Decode stage of the RV32I five-stage pipeline, directly downstream of `if_stage`. It consumes `pc_o`/`instr_o`/`valid_o` from IF, decodes the instruction and reads the 32x32 register file. It drives a registered ID/EX bundle and generates the load-use stall that feeds IF `stall_i`. The register file lives inside this block and is written by the writeback port.

---
 rtl/id_stage.sv | 201 ++++++++++++++++++++
 tb/tb_id_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// RV32I decode stage: instruction decode, 32x32 register file with write-through
// bypass, load-use hazard detection and the registered ID/EX bundle.
module id_stage #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  input  logic        valid_i,
  input  logic        flush_i,
  input  logic        hold_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_mem_read_i,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_data_i,
  output logic        stall_o,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o,
  output logic [31:0] rs1_data_o,
  output logic [31:0] rs2_data_o,
  output logic [31:0] imm_o,
  output logic [3:0]  alu_op_o,
  output logic        alu_a_pc_o,
  output logic        alu_b_imm_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [2:0]  mem_funct3_o,
  output logic        reg_write_o,
  output logic [1:0]  wb_sel_o,
  output logic        branch_o,
  output logic        jal_o,
  output logic        jalr_o,
  output logic        illegal_o
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7;
  localparam logic [3:0] ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_a_pc;
    logic       alu_b_imm;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] mem_funct3;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic       illegal;
  } ctrl_t;

  // alt selects SUB/SRA; callers gate it so ADDI with a negative imm stays ADD
  function automatic logic [3:0] alu_fn(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_fn = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_fn = ALU_SLL;
      3'b010:  alu_fn = ALU_SLT;
      3'b011:  alu_fn = ALU_SLTU;
      3'b100:  alu_fn = ALU_XOR;
      3'b101:  alu_fn = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_fn = ALU_OR;
      default: alu_fn = ALU_AND;
    endcase
  endfunction

  logic [31:0] regs [32];

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        f7b5;
  logic [4:0]  rs1, rs2, rd;
  logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm;
  ctrl_t       dec, ctrl_q;
  logic        rs1_used, rs2_used, load_use;
  logic [31:0] rs1_data, rs2_data;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign f7b5   = instr_i[30];
  assign rs1    = instr_i[19:15];
  assign rs2    = instr_i[24:20];
  assign rd     = instr_i[11:7];

  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'h000};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  always_comb begin
    dec      = '0;
    imm      = '0;
    rs1_used = 1'b1;
    rs2_used = 1'b0;
    case (opcode)
      OPC_LUI:    begin dec.alu_op = ALU_PASSB; dec.alu_b_imm = 1'b1; dec.reg_write = 1'b1;
                        imm = imm_u; rs1_used = 1'b0; end
      OPC_AUIPC:  begin dec.alu_a_pc = 1'b1; dec.alu_b_imm = 1'b1; dec.reg_write = 1'b1;
                        imm = imm_u; rs1_used = 1'b0; end
      OPC_JAL:    begin dec.alu_a_pc = 1'b1; dec.alu_b_imm = 1'b1; dec.reg_write = 1'b1;
                        dec.wb_sel = 2'd2; dec.jal = 1'b1; imm = imm_j; rs1_used = 1'b0; end
      OPC_JALR:   begin dec.alu_b_imm = 1'b1; dec.reg_write = 1'b1; dec.wb_sel = 2'd2;
                        dec.jalr = 1'b1; imm = imm_i; end
      OPC_BRANCH: begin dec.alu_op = ALU_SUB; dec.branch = 1'b1; dec.mem_funct3 = funct3;
                        imm = imm_b; rs2_used = 1'b1; end
      OPC_LOAD:   begin dec.alu_b_imm = 1'b1; dec.mem_read = 1'b1; dec.mem_funct3 = funct3;
                        dec.reg_write = 1'b1; dec.wb_sel = 2'd1; imm = imm_i; end
      OPC_STORE:  begin dec.alu_b_imm = 1'b1; dec.mem_write = 1'b1; dec.mem_funct3 = funct3;
                        imm = imm_s; rs2_used = 1'b1; end
      OPC_OPIMM:  begin dec.alu_op = alu_fn(funct3, f7b5 && funct3 == 3'b101);
                        dec.alu_b_imm = 1'b1; dec.reg_write = 1'b1; imm = imm_i; end
      OPC_OP:     begin dec.alu_op = alu_fn(funct3, f7b5); dec.reg_write = 1'b1;
                        rs2_used = 1'b1; end
      OPC_FENCE, OPC_SYSTEM: ;
      default:    dec.illegal = 1'b1;
    endcase
  end

  always_comb begin
    rs1_data = regs[rs1];
    rs2_data = regs[rs2];
    if (wb_we_i && wb_rd_i == rs1) rs1_data = wb_data_i;
    if (wb_we_i && wb_rd_i == rs2) rs2_data = wb_data_i;
    if (rs1 == 5'd0) rs1_data = '0;
    if (rs2 == 5'd0) rs2_data = '0;
  end

  assign load_use = valid_i && ex_mem_read_i && (ex_rd_i != 5'd0) &&
                    ((rs1_used && ex_rd_i == rs1) || (rs2_used && ex_rd_i == rs2));
  assign stall_o  = !flush_i && (hold_i || load_use);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_we_i && wb_rd_i != 5'd0) begin
      regs[wb_rd_i] <= wb_data_i;
    end
  end

  // ID/EX boundary
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o    <= 1'b0;
      ctrl_q     <= '0;
      pc_o       <= RESET_PC;
      rs1_o      <= '0;
      rs2_o      <= '0;
      rd_o       <= '0;
      rs1_data_o <= '0;
      rs2_data_o <= '0;
      imm_o      <= '0;
    end else if (flush_i || (!hold_i && load_use)) begin
      valid_o <= 1'b0;
      ctrl_q  <= '0;
    end else if (!hold_i) begin
      valid_o    <= valid_i;
      ctrl_q     <= valid_i ? dec : '0;
      pc_o       <= pc_i;
      rs1_o      <= rs1;
      rs2_o      <= rs2;
      rd_o       <= rd;
      rs1_data_o <= rs1_data;
      rs2_data_o <= rs2_data;
      imm_o      <= imm;
    end
  end

  assign alu_op_o     = ctrl_q.alu_op;
  assign alu_a_pc_o   = ctrl_q.alu_a_pc;
  assign alu_b_imm_o  = ctrl_q.alu_b_imm;
  assign mem_read_o   = ctrl_q.mem_read;
  assign mem_write_o  = ctrl_q.mem_write;
  assign mem_funct3_o = ctrl_q.mem_funct3;
  assign reg_write_o  = ctrl_q.reg_write;
  assign wb_sel_o     = ctrl_q.wb_sel;
  assign branch_o     = ctrl_q.branch;
  assign jal_o        = ctrl_q.jal;
  assign jalr_o       = ctrl_q.jalr;
  assign illegal_o    = ctrl_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed testbench for id_stage: decode formats, load-use stall, bypass,
// flush/hold priority, illegal opcode and asynchronous reset.
module tb_id_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, instr;
  logic        valid, flush, hold;
  logic [4:0]  ex_rd;
  logic        ex_mem_read;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall, valid_q;
  logic [31:0] pc_q;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] rs1_data, rs2_data, imm;
  logic [3:0]  alu_op;
  logic        alu_a_pc, alu_b_imm, mem_read, mem_write;
  logic [2:0]  mem_funct3;
  logic        reg_write;
  logic [1:0]  wb_sel;
  logic        branch, jal, jalr, illegal;

  int checks = 0;
  int failures = 0;

  id_stage #(.RESET_PC(32'h00000000)) dut (
    .clk_i(clk), .rst_i(rst), .pc_i(pc), .instr_i(instr), .valid_i(valid),
    .flush_i(flush), .hold_i(hold), .ex_rd_i(ex_rd), .ex_mem_read_i(ex_mem_read),
    .wb_we_i(wb_we), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
    .stall_o(stall), .valid_o(valid_q), .pc_o(pc_q),
    .rs1_o(rs1), .rs2_o(rs2), .rd_o(rd),
    .rs1_data_o(rs1_data), .rs2_data_o(rs2_data), .imm_o(imm),
    .alu_op_o(alu_op), .alu_a_pc_o(alu_a_pc), .alu_b_imm_o(alu_b_imm),
    .mem_read_o(mem_read), .mem_write_o(mem_write), .mem_funct3_o(mem_funct3),
    .reg_write_o(reg_write), .wb_sel_o(wb_sel),
    .branch_o(branch), .jal_o(jal), .jalr_o(jalr), .illegal_o(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] p, input logic [31:0] ins);
    pc = p; instr = ins; valid = 1'b1;
    step();
  endtask

  initial begin
    rst = 1'b1; pc = '0; instr = '0; valid = 1'b0; flush = 1'b0; hold = 1'b0;
    ex_rd = '0; ex_mem_read = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    #1;
    check("reset_valid", {31'd0, valid_q}, 32'd0);
    check("reset_pc", pc_q, 32'h0);
    check("reset_regw", {31'd0, reg_write}, 32'd0);
    step(); step();
    rst = 1'b0;

    // preload x2 = 7
    wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'd7;
    step();
    wb_we = 1'b0;

    issue(32'h100, 32'h00500093);                   // addi x1,x0,5
    check("addi_valid", {31'd0, valid_q}, 32'd1);
    check("addi_rd", {27'd0, rd}, 32'd1);
    check("addi_imm", imm, 32'd5);
    check("addi_aluop", {28'd0, alu_op}, 32'd0);
    check("addi_bimm", {31'd0, alu_b_imm}, 32'd1);
    check("addi_regw", {31'd0, reg_write}, 32'd1);
    check("addi_pc", pc_q, 32'h100);

    issue(32'h104, 32'hFE000CE3);                   // beq x0,x0,-8
    check("beq_imm", imm, 32'hFFFFFFF8);
    check("beq_branch", {31'd0, branch}, 32'd1);
    check("beq_regw", {31'd0, reg_write}, 32'd0);
    check("beq_aluop", {28'd0, alu_op}, 32'd1);

    // load-use hazard on x2
    ex_mem_read = 1'b1; ex_rd = 5'd2;
    pc = 32'h108; instr = 32'h002101B3;             // add x3,x2,x2
    #1;
    check("lu_stall", {31'd0, stall}, 32'd1);
    step();
    check("lu_bubble_valid", {31'd0, valid_q}, 32'd0);
    check("lu_bubble_regw", {31'd0, reg_write}, 32'd0);
    ex_mem_read = 1'b0;
    #1;
    check("lu_release_stall", {31'd0, stall}, 32'd0);
    step();
    check("add_valid", {31'd0, valid_q}, 32'd1);
    check("add_rd", {27'd0, rd}, 32'd3);
    check("add_rs1data", rs1_data, 32'd7);
    check("add_rs2data", rs2_data, 32'd7);
    check("add_bimm", {31'd0, alu_b_imm}, 32'd0);

    // write-through bypass of x5
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
    issue(32'h10C, 32'h00028313);                   // addi x6,x5,0
    check("bypass_rs1", rs1_data, 32'hDEADBEEF);
    wb_we = 1'b0;
    issue(32'h110, 32'h00028313);
    check("rf_x5", rs1_data, 32'hDEADBEEF);

    // x0 is never written
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234;
    issue(32'h114, 32'h00500093);
    check("x0_bypass", rs1_data, 32'd0);
    wb_we = 1'b0;
    issue(32'h118, 32'h00500093);
    check("x0_read", rs1_data, 32'd0);

    // flush beats hold
    flush = 1'b1; hold = 1'b1;
    pc = 32'h11C; instr = 32'h00500093;
    #1;
    check("flush_stall", {31'd0, stall}, 32'd0);
    step();
    check("flush_valid", {31'd0, valid_q}, 32'd0);
    check("flush_regw", {31'd0, reg_write}, 32'd0);
    flush = 1'b0; hold = 1'b0;

    // hold keeps outputs for 3 cycles
    issue(32'h120, 32'h002101B3);
    hold = 1'b1; pc = 32'h124; instr = 32'hFE000CE3;
    #1;
    check("hold_stall", {31'd0, stall}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_valid", {31'd0, valid_q}, 32'd1);
      check("hold_rd", {27'd0, rd}, 32'd3);
      check("hold_pc", pc_q, 32'h120);
      check("hold_branch", {31'd0, branch}, 32'd0);
    end
    hold = 1'b0;

    issue(32'h128, 32'h40210233);                   // sub x4,x2,x2
    check("sub_aluop", {28'd0, alu_op}, 32'd1);
    issue(32'h12C, 32'h40308093);                   // addi x1,x1,1027 (bit30 set)
    check("addi_neg_alt", {28'd0, alu_op}, 32'd0);
    issue(32'h130, 32'h4030D093);                   // srai x1,x1,3
    check("srai_aluop", {28'd0, alu_op}, 32'd7);
    issue(32'h134, 32'h00412283);                   // lw x5,4(x2)
    check("lw_memrd", {31'd0, mem_read}, 32'd1);
    check("lw_wbsel", {30'd0, wb_sel}, 32'd1);
    check("lw_f3", {29'd0, mem_funct3}, 32'd2);
    check("lw_imm", imm, 32'd4);
    issue(32'h138, 32'h010000EF);                   // jal x1,16
    check("jal_flag", {31'd0, jal}, 32'd1);
    check("jal_wbsel", {30'd0, wb_sel}, 32'd2);
    check("jal_imm", imm, 32'd16);
    check("jal_apc", {31'd0, alu_a_pc}, 32'd1);
    issue(32'h13C, 32'h123453B7);                   // lui x7,0x12345
    check("lui_imm", imm, 32'h12345000);
    check("lui_aluop", {28'd0, alu_op}, 32'd10);

    // valid_i low registers no controls
    valid = 1'b0; instr = 32'h00500093;
    step();
    check("novalid_valid", {31'd0, valid_q}, 32'd0);
    check("novalid_regw", {31'd0, reg_write}, 32'd0);

    issue(32'h140, 32'h0000007F);
    check("ill_flag", {31'd0, illegal}, 32'd1);
    check("ill_regw", {31'd0, reg_write}, 32'd0);
    check("ill_valid", {31'd0, valid_q}, 32'd1);

    // async reset mid-stream while a load-use stall is pending
    ex_mem_read = 1'b1; ex_rd = 5'd2; instr = 32'h002101B3;
    #2;
    rst = 1'b1;
    #1;
    check("rst_valid", {31'd0, valid_q}, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    check("rst_pc", pc_q, 32'h0);
    check("rst_rd", {27'd0, rd}, 32'd0);
    step();
    rst = 1'b0; ex_mem_read = 1'b0;
    issue(32'h200, 32'h002101B3);
    check("post_rst_valid", {31'd0, valid_q}, 32'd1);
    check("post_rst_rd", {27'd0, rd}, 32'd3);
    check("post_rst_rfclr", rs1_data, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
